wb_regfile: RTL

Architectural register file and writeback scoreboard at the consuming end of the MEM/WB pipeline register. It accepts the registered writeback bundle, selects memory or ALU data, and commits it to the integer (x) or floating-point (f) bank. It serves two combinational read ports to ID with same-cycle write bypass. It also keeps a per-register busy scoreboard: ID sets a bit at issue, writeback clears it, and hazard logic reads it.

---
 rtl/wb_regfile_pkg.sv | 31 +++
 rtl/wb_regfile_bank.sv | 45 ++++
 rtl/wb_regfile.sv | 99 +++++++++
 3 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared CPU definitions for the writeback stage: widths, register index type
// and the MEM/WB writeback bundle.
package wb_regfile_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int IDXW = 5;

  typedef logic [IDXW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0] xdata_t;
  typedef logic [NREG-1:0] reg_mask_t;

  typedef struct packed {
    xdata_t   mem_data;
    xdata_t   alu_data;
    logic     memtoreg;
    reg_idx_t rd;
    logic     regwrite;
    logic     floatwb;
  } wb_bundle_t;

  localparam reg_mask_t X0_MASK = reg_mask_t'(1);

  function automatic reg_mask_t idx_onehot(input reg_idx_t idx);
    reg_mask_t m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_regfile_bank.sv
// One architectural register bank: NREG x XLEN storage, one write port and two
// combinational read ports with same-cycle write bypass; optional hard-wired r0.
module reg_bank
  import wb_regfile_pkg::*;
#(
  parameter bit HARDZERO = 1'b0
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     we_i,
  input  reg_idx_t waddr_i,
  input  xdata_t   wdata_i,
  input  reg_idx_t raddr1_i,
  input  reg_idx_t raddr2_i,
  output xdata_t   rdata1_o,
  output xdata_t   rdata2_o
);

  xdata_t mem_q [NREG];
  logic   wr_en;

  assign wr_en = we_i && !(HARDZERO && (waddr_i == '0));

  // NOTE: the storage array is reset because the architecture guarantees
  // every register reads 0 after reset; a plain RAM macro cannot be used here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Reset masks both the stored value and the bypass path.
  assign rdata1_o = rst_i                             ? '0      :
                    (HARDZERO && (raddr1_i == '0))    ? '0      :
                    (wr_en && (waddr_i == raddr1_i))  ? wdata_i :
                                                        mem_q[raddr1_i];

  assign rdata2_o = rst_i                             ? '0      :
                    (HARDZERO && (raddr2_i == '0))    ? '0      :
                    (wr_en && (waddr_i == raddr2_i))  ? wdata_i :
                                                        mem_q[raddr2_i];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage register file: x/f banks with bypassed reads, plus the
// per-register busy scoreboard set at issue and cleared at commit.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  xdata_t   wb_mem_data_i,
  input  xdata_t   wb_alu_data_i,
  input  logic     wb_memtoreg_i,
  input  reg_idx_t wb_rd_i,
  input  logic     wb_regwrite_i,
  input  logic     wb_floatwb_i,
  input  logic     iss_valid_i,
  input  reg_idx_t iss_rd_i,
  input  logic     iss_float_i,
  input  reg_idx_t rs1_idx_i,
  input  reg_idx_t rs2_idx_i,
  input  logic     rs1_float_i,
  input  logic     rs2_float_i,
  output xdata_t   rs1_data_o,
  output xdata_t   rs2_data_o,
  output logic     rs1_busy_o,
  output logic     rs2_busy_o
);

  wb_bundle_t wb;
  xdata_t     wb_val;
  logic       we_x, we_f;

  assign wb = '{mem_data: wb_mem_data_i, alu_data: wb_alu_data_i,
                memtoreg: wb_memtoreg_i, rd: wb_rd_i,
                regwrite: wb_regwrite_i, floatwb: wb_floatwb_i};

  assign wb_val = wb.memtoreg ? wb.mem_data : wb.alu_data;
  assign we_x   = wb.regwrite && !wb.floatwb;
  assign we_f   = wb.regwrite &&  wb.floatwb;

  xdata_t x_rd1, x_rd2, f_rd1, f_rd2;

  reg_bank #(.HARDZERO(1'b1)) u_xbank (
    .clk_i, .rst_i,
    .we_i     (we_x),
    .waddr_i  (wb.rd),
    .wdata_i  (wb_val),
    .raddr1_i (rs1_idx_i),
    .raddr2_i (rs2_idx_i),
    .rdata1_o (x_rd1),
    .rdata2_o (x_rd2)
  );

  reg_bank #(.HARDZERO(1'b0)) u_fbank (
    .clk_i, .rst_i,
    .we_i     (we_f),
    .waddr_i  (wb.rd),
    .wdata_i  (wb_val),
    .raddr1_i (rs1_idx_i),
    .raddr2_i (rs2_idx_i),
    .rdata1_o (f_rd1),
    .rdata2_o (f_rd2)
  );

  assign rs1_data_o = rs1_float_i ? f_rd1 : x_rd1;
  assign rs2_data_o = rs2_float_i ? f_rd2 : x_rd2;

  // Scoreboard: set/clear masks per bank; x0 can never become busy.
  reg_mask_t busy_x_q, busy_x_d, busy_f_q, busy_f_d;
  reg_mask_t set_x, set_f, clr_x, clr_f;
  reg_mask_t eff_x, eff_f;

  assign set_x = (iss_valid_i && !iss_float_i) ? (idx_onehot(iss_rd_i) & ~X0_MASK) : '0;
  assign set_f = (iss_valid_i &&  iss_float_i) ?  idx_onehot(iss_rd_i)             : '0;
  assign clr_x = we_x ? idx_onehot(wb.rd) : '0;
  assign clr_f = we_f ? idx_onehot(wb.rd) : '0;

  // A new producer issued this cycle supersedes the one committing.
  assign busy_x_d = (busy_x_q & ~clr_x) | set_x;
  assign busy_f_d = (busy_f_q & ~clr_f) | set_f;

  // Read-side view: a bit being cleared right now reads as free unless re-set.
  assign eff_x = busy_x_q & ~(clr_x & ~set_x) & ~X0_MASK;
  assign eff_f = busy_f_q & ~(clr_f & ~set_f);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_x_q <= '0;
      busy_f_q <= '0;
    end else begin
      busy_x_q <= busy_x_d;
      busy_f_q <= busy_f_d;
    end
  end

  assign rs1_busy_o = !rst_i && (rs1_float_i ? eff_f[rs1_idx_i] : eff_x[rs1_idx_i]);
  assign rs2_busy_o = !rst_i && (rs2_float_i ? eff_f[rs2_idx_i] : eff_x[rs2_idx_i]);

endmodule
